// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the UART datapath
package uart_pkg;
   typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;
   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} tx_state_e;
   localparam int DEF_CLK_PER_BIT = 2604;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, head word visible on dout in the cycle it is popped
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic do_push, do_pop;
   assign full = count == (AW + 1)'(DEPTH);
   assign empty = count == '0;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign dout = mem[rptr];
   always_ff @(posedge CLK)
      if (do_push) mem[wptr] <= din;
   always_ff @(posedge CLK)
      if (RST) begin
         wptr <= '0;
         rptr <= '0;
         count <= '0;
      end else begin
         wptr <= wptr + AW'(do_push);
         rptr <= rptr + AW'(do_pop);
         count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
      end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: queued UART transmitter with configurable bit period, width, parity and stop bits
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_PER_BIT = DEF_CLK_PER_BIT,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [DATA_BITS-1:0]          din,
   input  logic                          valid,
   output logic                          ready,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          OUT
);
   localparam int TW = $clog2(CLK_PER_BIT);
   localparam int IW = $clog2(DATA_BITS);
   tx_state_e state;
   logic [TW-1:0] tmr;
   logic [IW-1:0] idx;
   logic [DATA_BITS-1:0] sh, head;
   logic pbit, pend, full, empty, tick, pop;
   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) fifo (
      .CLK(CLK), .RST(RST), .push(valid), .pop(pop), .din(din),
      .dout(head), .full(full), .empty(empty), .count(count)
   );
   assign ready = !full;
   assign busy = state != IDLE || !empty;
   assign tick = tmr == TW'(CLK_PER_BIT - 1);
   // from idle, a word is taken one cycle after the queue was seen non-empty
   assign pop = !empty && (state == IDLE ? pend : state == STOP && tick && idx == IW'(STOP_BITS - 1));
   always_ff @(posedge CLK)
      if (RST) begin
         state <= IDLE;
         OUT <= 1'b1;
         tmr <= '0;
         idx <= '0;
         sh <= '0;
         pbit <= 1'b0;
         pend <= 1'b0;
      end else begin
         pend <= !empty;
         tmr <= (pop || tick || state == IDLE) ? '0 : tmr + 1'b1;
         if (pop) begin
            state <= START;
            OUT <= 1'b0;
            idx <= '0;
            sh <= head;
            pbit <= ^head ^ (PARITY == int'(PAR_ODD));
         end else if (tick)
            case (state)
               START: begin
                  state <= DATA;
                  OUT <= sh[0];
                  sh <= sh >> 1;
               end
               DATA: if (idx == IW'(DATA_BITS - 1)) begin
                  state <= PARITY != 0 ? PAR : STOP;
                  OUT <= PARITY != 0 ? pbit : 1'b1;
                  idx <= '0;
               end else begin
                  OUT <= sh[0];
                  sh <= sh >> 1;
                  idx <= idx + 1'b1;
               end
               PAR: begin
                  state <= STOP;
                  OUT <= 1'b1;
               end
               STOP: if (idx == IW'(STOP_BITS - 1)) state <= IDLE; else idx <= idx + 1'b1;
               default: state <= IDLE;
            endcase
      end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: three framing configurations checked cycle by cycle against a queue-and-waveform model
module tb_uart_tx_fifo;
   localparam int CPB = 4;
   localparam int DBS [3] = '{8, 7, 7};
   localparam int PRS [3] = '{0, 2, 1};
   localparam int SBS [3] = '{1, 2, 2};
   logic clk = 1'b0, rst = 1'b1, chk_en = 1'b0;
   logic [2:0] vld = '0;
   logic [8:0] din [3];
   logic [8:0] b2b [3] = '{9'h000, 9'h0FF, 9'h055};
   logic [9:0] pat;
   int n_chk = 0, n_fail = 0, acc;
   initial forever #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic tk(input int n);
      repeat (n) @(negedge clk);
   endtask
   for (genvar g = 0; g < 3; g++) begin : cfg
      localparam int DB = DBS[g], PR = PRS[g], SB = SBS[g];
      logic [DB-1:0] d;
      logic ready, busy, out;
      logic [2:0] count;
      int mq [$];
      bit wave [$];
      bit act = 1'b0, neq = 1'b0, eo = 1'b1;
      assign d = din[g][DB-1:0];
      uart_tx_fifo #(.CLK_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(PR), .STOP_BITS(SB), .FIFO_DEPTH(4)) dut (
         .CLK(clk), .RST(rst), .din(d), .valid(vld[g]), .ready(ready),
         .busy(busy), .count(count), .OUT(out)
      );
      // model: a frame is a list of line levels; a new one starts when the previous list runs out
      initial forever begin
         bit pop, acc_m, par;
         int w, b;
         @(posedge clk);
         if (rst) begin
            mq.delete();
            wave.delete();
            act = 1'b0;
            neq = 1'b0;
            eo = 1'b1;
         end else begin
            pop = wave.size() == 0 && mq.size() > 0 && (act || neq);
            acc_m = vld[g] && mq.size() < 4;
            neq = mq.size() > 0;
            if (pop) begin
               w = mq.pop_front();
               par = ($countones(w) % 2 == 1) ^ (PR == 2);
               for (int i = 0; i < CPB * (1 + DB + (PR != 0 ? 1 : 0) + SB); i++) begin
                  b = i / CPB;
                  wave.push_back(b == 0 ? 1'b0 : b <= DB ? w[b-1] : (b == DB + 1 && PR != 0) ? par : 1'b1);
               end
            end
            if (acc_m) mq.push_back(int'(d));
            act = wave.size() > 0;
            eo = act ? wave.pop_front() : 1'b1;
         end
      end
      initial forever begin
         @(negedge clk);
         if (chk_en) begin
            check($sformatf("out%0d", g), 32'(out), 32'(eo));
            check($sformatf("count%0d", g), 32'(count), 32'(mq.size()));
            check($sformatf("busy%0d", g), 32'(busy), 32'(act || mq.size() > 0));
            check($sformatf("ready%0d", g), 32'(ready), 32'(mq.size() < 4));
         end
      end
   end
   task automatic drain(input int lim);
      int n = 0;
      while (cfg[0].busy && n < lim) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(cfg[0].busy), 32'(0));
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      for (int j = 0; j < 3; j++) din[j] = '0;
      tk(3);
      rst = 1'b0;
      chk_en = 1'b1;
      check("rst_out", 32'(cfg[0].out), 32'(1));
      check("rst_ready", 32'(cfg[0].ready), 32'(1));
      check("rst_busy", 32'(cfg[0].busy), 32'(0));
      check("rst_count", 32'(cfg[0].count), 32'(0));
      din[0] = 9'h0A5;
      vld[0] = 1'b1;
      tk(1);
      vld[0] = 1'b0;
      check("lat_k_cnt", 32'(cfg[0].count), 32'(1));
      check("lat_k_out", 32'(cfg[0].out), 32'(1));
      tk(1);
      check("lat_k1_out", 32'(cfg[0].out), 32'(1));
      tk(1);
      check("lat_k2_out", 32'(cfg[0].out), 32'(0));
      pat = {1'b1, 8'hA5, 1'b0};
      for (int i = 0; i < 10; i++) begin
         tk(2);
         check($sformatf("a5_bit%0d", i), 32'(cfg[0].out), 32'(pat[i]));
         tk(i < 9 ? 2 : 1);
      end
      check("busy_hold", 32'(cfg[0].busy), 32'(1));
      tk(1);
      check("busy_clr", 32'(cfg[0].busy), 32'(0));
      for (int i = 0; i < 3; i++) begin
         din[0] = b2b[i];
         vld[0] = 1'b1;
         tk(1);
         check("b2b_cnt", 32'(cfg[0].count), 32'(i == 0 ? 1 : 2));
      end
      vld[0] = 1'b0;
      drain(300);
      din[0] = 9'($urandom);
      vld[0] = 1'b1;
      tk(1);
      vld[0] = 1'b0;
      tk(2);
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         din[0] = 9'($urandom);
         vld[0] = 1'b1;
         acc += int'(cfg[0].ready);
         tk(1);
      end
      vld[0] = 1'b0;
      check("full_acc", 32'(acc), 32'(4));
      check("full_cnt", 32'(cfg[0].count), 32'(4));
      check("full_ready", 32'(cfg[0].ready), 32'(0));
      drain(400);
      for (int i = 0; i < 4; i++) begin
         din[0] = 9'($urandom);
         vld[0] = 1'b1;
         tk(1);
      end
      vld[0] = 1'b0;
      tk(38);
      din[0] = 9'($urandom);
      vld[0] = 1'b1;
      tk(1);
      vld[0] = 1'b0;
      check("push_pop_cnt", 32'(cfg[0].count), 32'(3));
      drain(400);
      for (int i = 0; i < 3; i++) begin
         din[0] = 9'($urandom);
         vld[0] = 1'b1;
         tk(1);
      end
      vld[0] = 1'b0;
      check("pre_rst_cnt", 32'(cfg[0].count), 32'(2));
      tk(17);
      rst = 1'b1;
      tk(1);
      rst = 1'b0;
      check("mid_rst_out", 32'(cfg[0].out), 32'(1));
      check("mid_rst_cnt", 32'(cfg[0].count), 32'(0));
      check("mid_rst_busy", 32'(cfg[0].busy), 32'(0));
      check("mid_rst_ready", 32'(cfg[0].ready), 32'(1));
      tk(60);
      check("post_rst_out", 32'(cfg[0].out), 32'(1));
      check("post_rst_busy", 32'(cfg[0].busy), 32'(0));
      din[1] = 9'h003;
      din[2] = 9'h003;
      vld[2:1] = 2'b11;
      tk(1);
      vld[2:1] = 2'b00;
      tk(36);
      check("par_odd", 32'(cfg[1].out), 32'(1));
      check("par_even", 32'(cfg[2].out), 32'(0));
      tk(2);
      check("stop_first", 32'(cfg[1].out), 32'(1));
      tk(7);
      check("stop_last", 32'(cfg[1].out), 32'(1));
      check("stop_busy", 32'(cfg[1].busy), 32'(1));
      tk(1);
      check("stop_done", 32'(cfg[1].busy), 32'(0));
      for (int c = 0; c < 3000; c++) begin
         for (int j = 0; j < 3; j++) begin
            vld[j] = $urandom_range(0, 3) == 0;
            din[j] = 9'($urandom);
         end
         rst = $urandom_range(0, 799) == 0;
         tk(1);
      end
      rst = 1'b0;
      vld = '0;
      tk(500);
      check("end_busy0", 32'(cfg[0].busy), 32'(0));
      check("end_busy1", 32'(cfg[1].busy), 32'(0));
      check("end_busy2", 32'(cfg[2].busy), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
